// File: rtl/multi_sel_pkg.sv
// Shared definitions for multi_sel: phase encoding, default widths and phase factors.
package multi_sel_pkg;

  typedef enum logic [1:0] {
    PH_X1 = 2'd0,
    PH_X3 = 2'd1,
    PH_X7 = 2'd2,
    PH_X8 = 2'd3
  } phase_t;

  localparam int DIN_W_DEF  = 8;
  localparam int DOUT_W_DEF = 11;

  localparam int FACT_X1 = 1;
  localparam int FACT_X3 = 3;
  localparam int FACT_X7 = 7;
  localparam int FACT_X8 = 8;

  function automatic int factor_of(phase_t ph);
    case (ph)
      PH_X1:   factor_of = FACT_X1;
      PH_X3:   factor_of = FACT_X3;
      PH_X7:   factor_of = FACT_X7;
      default: factor_of = FACT_X8;
    endcase
  endfunction

  function automatic phase_t next_phase(phase_t ph);
    case (ph)
      PH_X1:   next_phase = PH_X3;
      PH_X3:   next_phase = PH_X7;
      PH_X7:   next_phase = PH_X8;
      default: next_phase = PH_X1;
    endcase
  endfunction

endpackage

// File: rtl/multi_sel_shift_add.sv
// Combinational constant-factor multiplier (x1/x3/x7/x8) built from shifts and adds only.
module multi_sel_shift_add
  import multi_sel_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DIN_W + 3
) (
  input  logic [DIN_W-1:0]  opnd,
  input  phase_t            phase,
  output logic [DOUT_W-1:0] prod
);

  logic [DOUT_W-1:0] ext;
  logic [DOUT_W-1:0] x3;
  logic [DOUT_W-1:0] x7;
  logic [DOUT_W-1:0] x8;

  // Three guard bits in the output width keep x8 of the largest operand exact.
  always_comb begin
    ext = DOUT_W'(opnd);
    x3  = (ext << 1) + ext;
    x8  = ext << 3;
    x7  = x8 - ext;
  end

  always_comb begin
    prod = ext;
    case (phase)
      PH_X1:   prod = ext;
      PH_X3:   prod = x3;
      PH_X7:   prod = x7;
      PH_X8:   prod = x8;
      default: prod = ext;
    endcase
  end

endmodule

// File: rtl/multi_sel.sv
// Four-phase sequential multiplier: captures d every fourth cycle and emits d*1, d*3, d*7, d*8.
// Optional simulation assertions are enabled with the macro MULTI_SEL_ASSERT_EN.
module multi_sel
  import multi_sel_pkg::*;
#(
  parameter  int DIN_W  = DIN_W_DEF,
  localparam int DOUT_W = DIN_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  d,
  output logic              input_grant,
  output logic [DOUT_W-1:0] out
);

  phase_t            phase;
  phase_t            phase_nxt;
  logic [DIN_W-1:0]  d_reg;
  logic [DIN_W-1:0]  opnd;
  logic [DOUT_W-1:0] prod;

  always_ff @(posedge clk) begin
    if (rst) phase <= PH_X1;
    else     phase <= phase_nxt;
  end

  // On the X1 edge the fresh operand bypasses d_reg so out = d appears one cycle after sampling.
  always_comb begin
    phase_nxt = next_phase(phase);
    opnd      = d_reg;
    if (phase == PH_X1) opnd = d;
  end

  multi_sel_shift_add #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_shift_add (
    .opnd  (opnd),
    .phase (phase),
    .prod  (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg       <= '0;
      out         <= '0;
      input_grant <= 1'b0;
    end else begin
      if (phase == PH_X1) d_reg <= d;
      out         <= prod;
      input_grant <= (phase == PH_X1);
    end
  end

`ifdef MULTI_SEL_ASSERT_EN
  phase_t chk_ph;
  logic   chk_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_vld <= 1'b0;
      chk_ph  <= PH_X1;
    end else begin
      chk_vld <= 1'b1;
      chk_ph  <= phase;
    end
  end

  a_product: assert property (@(posedge clk) disable iff (rst)
    chk_vld |-> (int'(out) == int'(d_reg) * factor_of(chk_ph)));

  a_grant_phase: assert property (@(posedge clk) disable iff (rst)
    chk_vld |-> (input_grant == (chk_ph == PH_X1)));

  a_grant_spacing: assert property (@(posedge clk) disable iff (rst)
    input_grant |=> !input_grant [*3]);

  a_phase_legal: assert property (@(posedge clk)
    phase inside {PH_X1, PH_X3, PH_X7, PH_X8});
`else
  // Assertion checkers are compiled out in this build.
`endif

endmodule

// File: tb/tb_multi_sel.sv
// Self-checking bench for multi_sel: table-driven scenarios plus hand-written reset and random sequences.
module tb_multi_sel;

  localparam int DIN_W  = 8;
  localparam int DOUT_W = DIN_W + 3;

  typedef struct {
    logic              rst;
    logic [DIN_W-1:0]  d;
    logic [DOUT_W-1:0] exp_out;
    logic              exp_grant;
    string             name;
  } vec_t;

  typedef struct {
    logic [DOUT_W-1:0] out;
    logic              grant;
    string             name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIN_W-1:0]  d   = '0;
  logic              input_grant;
  logic [DOUT_W-1:0] out;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t tbl[$];

  multi_sel #(.DIN_W(DIN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .input_grant (input_grant),
    .out         (out)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs, queue its expectation, then check the registered result.
  task automatic step(input logic r, input logic [DIN_W-1:0] dv,
                      input int eo, input logic eg, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    d   = dv;
    e.out = DOUT_W'(eo);
    e.grant = eg;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, out=%0d grant=%0b", nm, out, input_grant);
    end else begin
      e = sb.pop_front();
      if (out !== e.out || input_grant !== e.grant) begin
        n_fail++;
        $display("FAIL %s: got out=%0d grant=%0b, expected out=%0d grant=%0b",
                 e.name, out, input_grant, e.out, e.grant);
      end
    end
  endtask

  task automatic add(input logic r, input int dv, input int eo, input logic eg, input string nm);
    vec_t v;
    v.rst = r;
    v.d = DIN_W'(dv);
    v.exp_out = DOUT_W'(eo);
    v.exp_grant = eg;
    v.name = nm;
    tbl.push_back(v);
  endtask

  initial begin
    int f[4];
    f[0] = 1; f[1] = 3; f[2] = 7; f[3] = 8;

    // Reset for two edges with a nonzero d that must not be captured.
    add(1, 99, 0, 0, "reset0");
    add(1, 99, 0, 0, "reset1");
    // d=143 held for two full sequences.
    for (int k = 0; k < 2; k++) begin
      add(0, 143, 143,  1, "s1_x1");
      add(0, 143, 429,  0, "s1_x3");
      add(0, 143, 1001, 0, "s1_x7");
      add(0, 143, 1144, 0, "s1_x8");
    end
    // Full-scale operand.
    add(0, 255, 255,  1, "s2_x1");
    add(0, 255, 765,  0, "s2_x3");
    add(0, 255, 1785, 0, "s2_x7");
    add(0, 255, 2040, 0, "s2_x8");
    // d changes after capture; the change is only seen at the next X1.
    add(0, 7, 7,  1, "s3_x1");
    add(0, 6, 21, 0, "s3_x3");
    add(0, 6, 49, 0, "s3_x7");
    add(0, 6, 56, 0, "s3_x8");
    add(0, 6, 6,  1, "s3b_x1");
    add(0, 9, 18, 0, "s3b_x3");
    add(0, 9, 42, 0, "s3b_x7");
    add(0, 9, 48, 0, "s3b_x8");
    // Zero operand still pulses the grant.
    add(0, 0, 0, 1, "s5_x1");
    add(0, 0, 0, 0, "s5_x3");
    add(0, 0, 0, 0, "s5_x7");
    add(0, 0, 0, 0, "s5_x8");

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].d, int'(tbl[i].exp_out), tbl[i].exp_grant, tbl[i].name);

    // Reset landing on the X7 edge aborts the sequence; release captures the current d.
    step(0, 128, 128, 1, "s4_x1");
    step(0, 128, 384, 0, "s4_x3");
    step(1, 128, 0,   0, "s4_rst");
    step(0, 129, 129, 1, "s4_x1b");
    step(0, 129, 387, 0, "s4_x3b");
    step(0, 129, 903, 0, "s4_x7b");
    step(0, 129, 1032, 0, "s4_x8b");

    // Random operands, with d scrambled in the non-capture phases.
    for (int k = 0; k < 8; k++) begin
      int v;
      v = int'($urandom_range(0, 255));
      for (int p = 0; p < 4; p++)
        step(0, (p == 0) ? DIN_W'(v) : DIN_W'($urandom_range(0, 255)),
             v * f[p], (p == 0), $sformatf("rnd%0d_p%0d", k, p));
    end

    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_sel.md
MULTI_SEL -- requirements
Module: multi_sel

Interface
REQ-001 The module SHALL have parameter DIN_W, default 8, data input width in bits; output width DOUT_W SHALL equal DIN_W+3.
REQ-002 The module SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The module SHALL have port d, input, DIN_W, unsigned operand, sampled only in phase X1.
REQ-005 The module SHALL have port input_grant, output, 1, registered; high for exactly the one cycle in which d was captured.
REQ-006 The module SHALL have port out, output, DOUT_W, registered unsigned product of the captured operand and the current phase factor.

Function
REQ-007 The block SHALL cycle through four phases, X1->X3->X7->X8->X1, advancing one phase per clock edge while rst is low.
REQ-008 Phase X1 edge SHALL:
- load d into internal register d_reg;
- set out = d (zero-extended);
- set input_grant = 1.
REQ-009 On the X3, X7 and X8 edges, out SHALL be d_reg*3, d_reg*7 and d_reg*8 respectively, and input_grant SHALL be 0.
REQ-010 Products SHALL be formed only by shifts and adds (x3=(d<<1)+d, x7=(d<<3)-d, x8=d<<3), with no multiply operator.
REQ-011 out SHALL never overflow; max value 255*8=2040 fits in 11 bits.
REQ-012 Changes on d during X3/X7/X8 SHALL be ignored; only the value at the X1 edge is used.
REQ-013 Latency SHALL be 1 cycle from d sampling to out=d*1, and 4 cycles total to out=d*8.
REQ-014 A new operand SHALL be captured every 4th cycle, with no stall and no back-pressure.

Reset
REQ-015 While rst=1 at a clock edge, the block SHALL set phase=X1, d_reg=0, out=0 and input_grant=0.
REQ-016 The first edge with rst=0 SHALL be an X1 edge (capture d, input_grant=1).
REQ-017 Reset asserted mid-sequence SHALL abort the sequence at the next edge; the partial result is discarded.

Configuration
REQ-018 When macro MULTI_SEL_ASSERT_EN is defined, the block SHALL include simulation assertions checking:
- out equals d_reg times the phase factor one cycle after each non-reset edge;
- input_grant is one-hot in time (one cycle in four);
- the phase never holds an illegal encoding.
REQ-019 When MULTI_SEL_ASSERT_EN is undefined, no assertion code SHALL be compiled, and functional behaviour SHALL be identical.

Structure
REQ-020 Package multi_sel_pkg SHALL hold:
- phase enum (PH_X1, PH_X3, PH_X7, PH_X8, 2-bit);
- default widths DIN_W=8, DOUT_W=11;
- factor constants 1/3/7/8.
REQ-021 Combinational sub-module multi_sel_shift_add SHALL compute the product from d_reg and the phase; the top holds the phase FSM and the output registers.

Verification
REQ-022 Scenario 1: rst=1 for 2 edges, then d=143 held -> out 143, 429, 1001, 1144, then repeats 143; input_grant 1,0,0,0 repeating.
REQ-023 Scenario 2: d=255 -> out 255, 765, 1785, 2040; no overflow.
REQ-024 Scenario 3: d=7 at the X1 edge, d=6 from the X3 edge on -> out 7, 21, 49, 56, then next X1 captures 6 -> 6, 18, 42, 48.
REQ-025 Scenario 4: rst asserted at the X7 edge of d=128 -> next edge out=0, input_grant=0; after release, first edge captures current d=129 -> 129, 387, 903, 1032.
REQ-026 Scenario 5: d=0 -> out 0 in all four phases, input_grant still pulses once per four cycles.
REQ-027 Scenario 6: with MULTI_SEL_ASSERT_EN defined, scenarios 1-5 SHALL run with zero assertion failures.
